// File: rtl/pooling_pkg.sv
// Shared types and helpers for the pooling blocks: FSM state encoding, counter width and lane slicing.
// The word width defaults to the DATA_WIDTH macro (32 when the macro is not defined).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pooling_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_WAIT  = 2'd2
    } pool_state_e;

    localparam int unsigned DEF_KERNEL_SIZE = 2;
    localparam int unsigned DEF_OUTPUT_SIZE = 3;
    localparam int unsigned DEF_DATA_WIDTH  = `DATA_WIDTH;

    // Row and column counters both run 0..KERNEL_SIZE-1; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned kernel_size);
        return (kernel_size > 1) ? $clog2(kernel_size) : 1;
    endfunction

    // Lane 0 sits in the MSBs of every packed lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned n_lanes,
                                             input int unsigned width);
        return (n_lanes - 1 - lane) * width;
    endfunction

endpackage

// File: rtl/pooling_layer_fp_max.sv
// Combinational two-input max of IEEE-754 words compared as sign-magnitude bit patterns.
// Operand a_i is the incumbent and wins every tie, including +0 against -0.
module pooling_layer_fp_max
    import pooling_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] max_o
);

    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-2:0] a_mag;
    logic [DATA_WIDTH-2:0] b_mag;
    logic                  both_zero;
    logic                  b_wins;

    assign a_neg     = a_i[DATA_WIDTH-1];
    assign b_neg     = b_i[DATA_WIDTH-1];
    assign a_mag     = a_i[DATA_WIDTH-2:0];
    assign b_mag     = b_i[DATA_WIDTH-2:0];
    assign both_zero = (a_mag == '0) && (b_mag == '0);

    // Opposite signs normally favour the positive word, but two zeros count as equal.
    always_comb begin
        if (a_neg != b_neg) begin
            b_wins = a_neg && !both_zero;
        end else if (a_neg) begin
            b_wins = b_mag < a_mag;
        end else begin
            b_wins = b_mag > a_mag;
        end
    end

    assign max_o = b_wins ? b_i : a_i;

endmodule

// File: rtl/pooling_layer_max_unit.sv
// Per-lane running max over a KERNEL_SIZE x KERNEL_SIZE window fed row by row from the pooling cache.
// Define POOL_RELU_EN to clamp any result whose sign bit is set (negatives and -0) to zero.
module pooling_layer_max_unit
    import pooling_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int unsigned OUTPUT_SIZE = DEF_OUTPUT_SIZE,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              kernel_calc_fin,
    input  logic                              window_start,
    input  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] data_in,
    output logic [OUTPUT_SIZE*DATA_WIDTH-1:0] data_out,
    output logic                              data_valid,
    output logic                              row_err
);

    localparam int unsigned    CNT_W    = cnt_width(KERNEL_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KERNEL_SIZE - 1);

    pool_state_e state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic [DATA_WIDTH-1:0] acc_q  [OUTPUT_SIZE];
    logic [DATA_WIDTH-1:0] acc_d  [OUTPUT_SIZE];
    logic [DATA_WIDTH-1:0] base_q [OUTPUT_SIZE];
    logic [DATA_WIDTH-1:0] base_d [OUTPUT_SIZE];
    logic [OUTPUT_SIZE*DATA_WIDTH-1:0] out_q, out_d;

    logic [DATA_WIDTH-1:0] sample_lane [OUTPUT_SIZE];
    logic [DATA_WIDTH-1:0] max_lane    [OUTPUT_SIZE];

    logic last_col;
    logic last_row;
    logic seed;
    logic sample_en;
    logic abort;
    logic row_start;

    assign last_col = (col_q == LAST_IDX);
    assign last_row = (row_q == LAST_IDX);
    assign seed     = (row_q == '0) && (col_q == '0);

    for (genvar g = 0; g < OUTPUT_SIZE; g++) begin : g_lane
        localparam int unsigned LSB = lane_lsb(g, OUTPUT_SIZE, DATA_WIDTH);

        assign sample_lane[g] = data_in[LSB +: DATA_WIDTH];

        pooling_layer_fp_max #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fp_max (
            .a_i   (acc_q[g]),
            .b_i   (sample_lane[g]),
            .max_o (max_lane[g])
        );
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        sample_en = 1'b0;
        abort     = 1'b0;
        row_start = 1'b0;

        unique case (state_q)
            S_IDLE, S_WAIT: begin
                if (kernel_calc_fin) begin
                    state_d   = S_ACCUM;
                    col_d     = '0;
                    row_start = 1'b1;
                    if (window_start) row_d = '0;
                end else if (window_start) begin
                    state_d = S_IDLE;
                    row_d   = '0;
                end
            end

            S_ACCUM: begin
                if (kernel_calc_fin && !last_col) begin
                    // Mid-row load: restart the row; a simultaneous window_start makes it a clean new window.
                    abort = 1'b1;
                    col_d = '0;
                    if (window_start) row_d = '0;
                    else              err_d = 1'b1;
                end else begin
                    sample_en = 1'b1;
                    if (last_col) begin
                        col_d   = '0;
                        valid_d = last_row;
                        row_d   = (last_row || window_start) ? '0 : row_q + CNT_W'(1);
                        // A load on the final column is the next row arriving back-to-back.
                        if (kernel_calc_fin) begin
                            state_d   = S_ACCUM;
                            row_start = 1'b1;
                        end else if (window_start || last_row) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        col_d = col_q + CNT_W'(1);
                        if (window_start) begin
                            state_d = S_IDLE;
                            row_d   = '0;
                            col_d   = '0;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                col_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    // base holds acc as it stood when the current row began, so an aborted row leaves no trace.
    always_comb begin
        out_d = out_q;
        for (int l = 0; l < OUTPUT_SIZE; l++) begin
            if (sample_en) begin
                acc_d[l] = seed ? sample_lane[l] : max_lane[l];
            end else if (abort) begin
                acc_d[l] = base_q[l];
            end else begin
                acc_d[l] = acc_q[l];
            end
            base_d[l] = row_start ? acc_d[l] : base_q[l];
            if (valid_d) begin
`ifdef POOL_RELU_EN
                out_d[lane_lsb(l, OUTPUT_SIZE, DATA_WIDTH) +: DATA_WIDTH] =
                    acc_d[l][DATA_WIDTH-1] ? '0 : acc_d[l];
`else
                out_d[lane_lsb(l, OUTPUT_SIZE, DATA_WIDTH) +: DATA_WIDTH] = acc_d[l];
`endif
            end
        end
    end

    // NOTE: acc/base are a handful of flops per lane rather than a RAM, so they take the async reset like everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
            for (int l = 0; l < OUTPUT_SIZE; l++) begin
                acc_q[l]  <= '0;
                base_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
        end
    end

    assign data_out   = out_q;
    assign data_valid = valid_q;
    assign row_err    = err_q;

endmodule

// File: tb/tb_pooling_layer_max_unit.sv
// Bench for pooling_layer_max_unit: directed and random cycle traces checked against a window-level max model.
// The model orders floats by a signed integer key and keeps the earliest sample on ties.
`timescale 1ns/1ps

module tb_pooling_layer_max_unit;

    localparam int K   = 2;
    localparam int N   = 3;
    localparam int DW  = 32;
    localparam int BUS = N * DW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           kcf;
    logic           ws;
    logic [BUS-1:0] din;
    logic [BUS-1:0] dout;
    logic           dvalid;
    logic           rerr;

    int n_checks = 0;
    int n_fail   = 0;

    bit             tr_kcf[$];
    bit             tr_ws[$];
    logic [BUS-1:0] tr_din[$];
    logic [BUS-1:0] exp_out;

    always #5 clk = ~clk;

    pooling_layer_max_unit #(
        .KERNEL_SIZE (K),
        .OUTPUT_SIZE (N),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .kernel_calc_fin (kcf),
        .window_start    (ws),
        .data_in         (din),
        .data_out        (dout),
        .data_valid      (dvalid),
        .row_err         (rerr)
    );

    task automatic check(input string tag, input logic [BUS-1:0] got, input logic [BUS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint key(input logic [31:0] f);
        longint mag;
        mag = longint'(f[30:0]);
        return f[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] out_ref(input logic [31:0] m);
`ifdef POOL_RELU_EN
        return m[31] ? 32'h0 : m;
`else
        return m;
`endif
    endfunction

    function automatic logic [BUS-1:0] pack3(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2);
        return {l0, l1, l2};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(4))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return {1'b0, 8'h7F, 23'($urandom)};
            3:       return {1'b1, 8'h7F, 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [BUS-1:0] rand_bus();
        return pack3(rand_word(), rand_word(), rand_word());
    endfunction

    task automatic add_cycle(input bit k, input bit w, input logic [BUS-1:0] d);
        tr_kcf.push_back(k);
        tr_ws.push_back(w);
        tr_din.push_back(d);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add_cycle(1'b0, 1'b0, rand_bus());
    endtask

    // Back-to-back puts the load strobe on the previous row's final sample cycle.
    task automatic add_kcf(input bit b2b, input bit w);
        if (b2b && tr_kcf.size() > 0) begin
            tr_kcf[tr_kcf.size()-1] = 1'b1;
            tr_ws[tr_ws.size()-1]   = w;
        end else begin
            add_cycle(1'b1, w, rand_bus());
        end
    endtask

    task automatic add_row(input logic [BUS-1:0] s0, input logic [BUS-1:0] s1);
        add_kcf(1'b0, 1'b0);
        add_cycle(1'b0, 1'b0, s0);
        add_cycle(1'b0, 1'b0, s1);
    endtask

    // Derive per-cycle expectations from the trace, then drive it and compare every cycle.
    task automatic run_trace();
        bit             exp_v[$];
        bit             exp_e[$];
        logic [BUS-1:0] exp_o[$];
        logic [BUS-1:0] row_buf[$];
        logic [BUS-1:0] win_buf[$];
        bit             active;
        int             start;
        int             rows;
        active = 1'b0;
        start  = 0;
        rows   = 0;
        for (int c = 0; c < tr_kcf.size(); c++) begin
            bit v;
            bit e;
            v = 1'b0;
            e = 1'b0;
            if (active && c > start) begin
                if (tr_kcf[c] && (c - start - 1) < K - 1) begin
                    e = !tr_ws[c];
                    row_buf.delete();
                    start = c;
                    if (tr_ws[c]) begin
                        win_buf.delete();
                        rows = 0;
                    end
                end else begin
                    row_buf.push_back(tr_din[c]);
                    if (c - start == K) begin
                        active = 1'b0;
                        foreach (row_buf[i]) win_buf.push_back(row_buf[i]);
                        row_buf.delete();
                        rows++;
                        if (rows == K) begin
                            v = 1'b1;
                            for (int l = 0; l < N; l++) begin
                                logic [31:0] best;
                                logic [31:0] s;
                                best = win_buf[0][(N-1-l)*DW +: DW];
                                for (int i = 1; i < win_buf.size(); i++) begin
                                    s = win_buf[i][(N-1-l)*DW +: DW];
                                    if (key(s) > key(best)) best = s;
                                end
                                exp_out[(N-1-l)*DW +: DW] = out_ref(best);
                            end
                            win_buf.delete();
                            rows = 0;
                        end
                    end
                end
            end
            if (!active) begin
                if (tr_ws[c]) begin
                    win_buf.delete();
                    rows = 0;
                end
                if (tr_kcf[c]) begin
                    active = 1'b1;
                    start  = c;
                end
            end
            exp_v.push_back(v);
            exp_e.push_back(e);
            exp_o.push_back(exp_out);
        end

        for (int c = 0; c < tr_kcf.size(); c++) begin
            kcf = tr_kcf[c];
            ws  = tr_ws[c];
            din = tr_din[c];
            @(posedge clk);
            #1;
            check($sformatf("data_valid@%0d", c), BUS'(dvalid), BUS'(exp_v[c]));
            check($sformatf("row_err@%0d", c), BUS'(rerr), BUS'(exp_e[c]));
            check($sformatf("data_out@%0d", c), dout, exp_o[c]);
        end
        kcf = 1'b0;
        ws  = 1'b0;
        tr_kcf.delete();
        tr_ws.delete();
        tr_din.delete();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        exp_out = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit last_row_end;
        rst_n   = 1'b0;
        kcf     = 1'b0;
        ws      = 1'b0;
        din     = '0;
        exp_out = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", dout, '0);
        check("reset_data_valid", BUS'(dvalid), '0);
        check("reset_row_err", BUS'(rerr), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lane 0 mixed values, lane 1 all negative, lane 2 -0 seeded then +0.
        add_idle(2);
        add_row(pack3(32'h3F80_0000, 32'hC040_0000, 32'h8000_0000),
                pack3(32'h3F00_0000, 32'hBF80_0000, 32'h0000_0000));
        add_idle(1);
        add_row(pack3(32'h4000_0000, 32'hC040_0000, 32'h0000_0000),
                pack3(32'hBF80_0000, 32'hC040_0000, 32'h0000_0000));
        add_idle(3);
        run_trace();
        check("plan_result", dout, pack3(out_ref(32'h4000_0000), out_ref(32'hBF80_0000), out_ref(32'h8000_0000)));

        // Early load one cycle into row 1; the large word on the abort cycle must not be sampled.
        add_row(pack3(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000),
                pack3(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000));
        add_idle(2);
        add_kcf(1'b0, 1'b0);
        add_cycle(1'b1, 1'b0, pack3(32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000));
        add_cycle(1'b0, 1'b0, pack3(32'h4000_0000, 32'h3E00_0000, 32'hC000_0000));
        add_cycle(1'b0, 1'b0, pack3(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000));
        add_idle(3);
        run_trace();
        check("abort_result", dout, pack3(32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000));

        // window_start after row 0 drops it; the next two rows form a fresh window.
        add_row(pack3(32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000),
                pack3(32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000));
        add_idle(1);
        add_cycle(1'b0, 1'b1, rand_bus());
        add_idle(1);
        add_row(pack3(32'h3F80_0000, 32'hBF80_0000, 32'h4040_0000),
                pack3(32'h3F00_0000, 32'hC000_0000, 32'h3F80_0000));
        add_row(pack3(32'h3E80_0000, 32'hC040_0000, 32'h3F80_0000),
                pack3(32'h0000_0000, 32'hBF00_0000, 32'h0000_0000));
        add_idle(3);
        run_trace();
        check("ws_result", dout, pack3(32'h3F80_0000, out_ref(32'hBF00_0000), 32'h4040_0000));

        // Reset in the middle of row 1 clears outputs without waiting for a clock edge.
        add_row(pack3(32'h4000_0000, 32'h4000_0000, 32'h4000_0000),
                pack3(32'h4000_0000, 32'h4000_0000, 32'h4000_0000));
        add_idle(1);
        add_kcf(1'b0, 1'b0);
        add_cycle(1'b0, 1'b0, pack3(32'h4100_0000, 32'h4100_0000, 32'h4100_0000));
        run_trace();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_data_out", dout, '0);
        check("async_reset_data_valid", BUS'(dvalid), '0);
        check("async_reset_row_err", BUS'(rerr), '0);
        do_reset();
        add_idle(1);
        add_row(pack3(32'h3F80_0000, 32'hBF80_0000, 32'h8000_0000),
                pack3(32'h3FC0_0000, 32'hC000_0000, 32'h8000_0000));
        add_row(pack3(32'h3F00_0000, 32'hC000_0000, 32'h8000_0000),
                pack3(32'h3F80_0000, 32'hC040_0000, 32'h8000_0000));
        add_idle(3);
        run_trace();
        check("post_reset_result", dout, pack3(32'h3FC0_0000, out_ref(32'hBF80_0000), out_ref(32'h8000_0000)));

        // Random windows with random gaps, back-to-back loads, aborts and window restarts.
        last_row_end = 1'b0;
        for (int w = 0; w < 30; w++) begin
            for (int r = 0; r < K; r++) begin
                bit b2b;
                bit wsk;
                int gap;
                b2b = last_row_end && ($urandom_range(2) == 0);
                wsk = ($urandom_range(9) == 0);
                gap = $urandom_range(2);
                if (!b2b) begin
                    for (int g = 0; g < gap; g++) add_cycle(1'b0, $urandom_range(11) == 0, rand_bus());
                end
                add_kcf(b2b, wsk);
                if ($urandom_range(5) == 0) add_cycle(1'b1, 1'b0, rand_bus());
                for (int i = 0; i < K; i++) add_cycle(1'b0, 1'b0, rand_bus());
                last_row_end = 1'b1;
            end
        end
        add_idle(3);
        run_trace();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
